// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch counter slice.
package stopwatch_pkg;

  localparam int FIELD_W     = 6;
  localparam int MAX_VAL_DEF = 59;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_ADJ   = 2'd2
  } state_t;

  // Increment that wraps to zero once the field reaches its terminal value.
  function automatic logic [FIELD_W-1:0] inc_wrap(input logic [FIELD_W-1:0] v,
                                                  input logic [FIELD_W-1:0] max_v);
    return (v >= max_v) ? '0 : v + FIELD_W'(1);
  endfunction

endpackage

// File: rtl/pause_press_detect.sv
// Pause button press detector: optional debouncer (STOPWATCH_DEBOUNCE_EN)
// followed by a rising-edge detector producing a one-cycle press pulse.
module pause_press_detect #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  if ((64'd1 << DB_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_cfg_err
    $error("pause_press_detect: DB_W too narrow for DEBOUNCE_CYCLES");
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] r_cnt;
  logic            r_db;
  logic            r_press;

  // The count only advances while raw disagrees with the filtered level;
  // agreement at any point restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_db    <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (i_btn == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_db    <= i_btn;
        r_press <= i_btn;
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
    end
  end

  assign o_press = r_press;
`else
  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= i_btn;
  end

  assign o_press = i_btn & ~r_prev;
`endif

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core with pause and manual adjust. Build with
// STOPWATCH_DEBOUNCE_EN to debounce pause_btn internally.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX_VAL         = MAX_VAL_DEF,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1hz,
  input  logic               tick_2hz,
  input  logic               pause_btn,
  input  logic               sel,
  input  logic               adj,
  output logic [FIELD_W-1:0] min,
  output logic [FIELD_W-1:0] sec,
  output logic               paused,
  output logic               rollover
);

  localparam logic [FIELD_W-1:0] W_MAX = FIELD_W'(MAX_VAL);

  state_t             r_state;
  logic               r_resume_pause;
  logic [FIELD_W-1:0] r_min;
  logic [FIELD_W-1:0] r_sec;
  logic               r_paused;
  logic               r_rollover;
  logic               w_press;

  pause_press_detect #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_press (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (pause_btn),
    .o_press (w_press)
  );

  // Priority in RUN/PAUSE: adj, then press, then tick; press in ADJ is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_resume_pause <= 1'b0;
      r_min          <= '0;
      r_sec          <= '0;
      r_paused       <= 1'b0;
      r_rollover     <= 1'b0;
    end else begin
      r_rollover <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (adj) begin
            r_state        <= ST_ADJ;
            r_resume_pause <= 1'b0;
          end else if (w_press) begin
            r_state  <= ST_PAUSE;
            r_paused <= 1'b1;
          end else if (tick_1hz) begin
            if (r_sec < W_MAX) begin
              r_sec <= r_sec + FIELD_W'(1);
            end else begin
              r_sec <= '0;
              if (r_min < W_MAX) begin
                r_min <= r_min + FIELD_W'(1);
              end else begin
                r_min      <= '0;
                r_rollover <= 1'b1;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (adj) begin
            r_state        <= ST_ADJ;
            r_resume_pause <= 1'b1;
          end else if (w_press) begin
            r_state  <= ST_RUN;
            r_paused <= 1'b0;
          end
        end
        ST_ADJ: begin
          if (!adj) begin
            r_state  <= r_resume_pause ? ST_PAUSE : ST_RUN;
            r_paused <= r_resume_pause;
          end else if (tick_2hz) begin
            if (sel) r_sec <= inc_wrap(r_sec, W_MAX);
            else     r_min <= inc_wrap(r_min, W_MAX);
          end
        end
        default: begin
          r_state  <= ST_RUN;
          r_paused <= 1'b0;
        end
      endcase
    end
  end

  assign min      = r_min;
  assign sec      = r_sec;
  assign paused   = r_paused;
  assign rollover = r_rollover;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: vector table plus hand-written
// sequences for pause, adjust, debounce and asynchronous reset.
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0, tick_2hz = 1'b0, pause_btn = 1'b0, sel = 1'b0, adj = 1'b0;
  logic [5:0] min, sec;
  logic       paused, rollover;

  int n_chk = 0;
  int n_err = 0;

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int HOLD = 6;
`else
  localparam int HOLD = 2;
`endif

  stopwatch_counter #(.MAX_VAL(59), .DEBOUNCE_CYCLES(4), .DB_W(3)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .pause_btn(pause_btn), .sel(sel), .adj(adj),
    .min(min), .sec(sec), .paused(paused), .rollover(rollover)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       t1, t2, btn, s, a;
    logic [5:0] emin, esec;
    logic       ep, er;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic t1, input logic t2, input logic b, input logic s, input logic a);
    tick_1hz = t1; tick_2hz = t2; pause_btn = b; sel = s; adj = a;
    @(posedge clk); #1;
    tick_1hz = 1'b0; tick_2hz = 1'b0;
  endtask

  task automatic press(input logic a);
    for (int k = 0; k < HOLD; k++) cyc(0, 0, 1, 0, a);
    for (int k = 0; k < HOLD; k++) cyc(0, 0, 0, 0, a);
  endtask

  task automatic chk_time(input string nm, input int m, input int s, input int p);
    chk({nm, ".min"}, min, m);
    chk({nm, ".sec"}, sec, s);
    chk({nm, ".paused"}, paused, p);
  endtask

  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cyc(vt[i].t1, vt[i].t2, vt[i].btn, vt[i].s, vt[i].a);
      chk($sformatf("vec%0d.min", i), min, vt[i].emin);
      chk($sformatf("vec%0d.sec", i), sec, vt[i].esec);
      chk($sformatf("vec%0d.paused", i), paused, vt[i].ep);
      chk($sformatf("vec%0d.rollover", i), rollover, vt[i].er);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            t1 t2 btn sel adj  min     sec     p  r
    vt[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 6'd1,  6'd1,  1'b0,1'b0}; // adj rise eats tick_1hz
    vt[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b1, 6'd2,  6'd1,  1'b0,1'b0};
    vt[2]  = '{1'b0,1'b1,1'b0,1'b1,1'b1, 6'd2,  6'd2,  1'b0,1'b0};
    vt[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 6'd2,  6'd2,  1'b0,1'b0};
    vt[4]  = '{1'b0,1'b1,1'b0,1'b1,1'b0, 6'd2,  6'd2,  1'b0,1'b0}; // adj fall wins over tick_2hz
    vt[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 6'd2,  6'd3,  1'b0,1'b0};
    vt[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 6'd59, 6'd59, 1'b0,1'b0};
    vt[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 6'd0,  6'd0,  1'b0,1'b1};
    vt[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 6'd0,  6'd0,  1'b0,1'b0};
    vt[9]  = '{1'b0,1'b1,1'b0,1'b1,1'b1, 6'd0,  6'd59, 1'b0,1'b0};
    vt[10] = '{1'b1,1'b0,1'b0,1'b1,1'b1, 6'd0,  6'd59, 1'b0,1'b0};
    vt[11] = '{1'b0,1'b1,1'b0,1'b1,1'b1, 6'd0,  6'd0,  1'b0,1'b0};
    vt[12] = '{1'b1,1'b0,1'b0,1'b1,1'b1, 6'd0,  6'd0,  1'b0,1'b0};
    vt[13] = '{1'b0,1'b1,1'b0,1'b1,1'b1, 6'd0,  6'd1,  1'b0,1'b0};
    vt[14] = '{1'b0,1'b1,1'b0,1'b0,1'b1, 6'd0,  6'd1,  1'b0,1'b0};
    vt[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 6'd0,  6'd1,  1'b0,1'b0};

    #1;
    chk_time("reset", 0, 0, 0);
    chk("reset.rollover", rollover, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 61; i++) begin
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
    chk_time("count61", 1, 1, 0);

    run_vec(0, 5);

    // preload 59:58 through adjust
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 57; i++) cyc(0, 1, 0, 0, 1);
    for (int i = 0; i < 55; i++) cyc(0, 1, 0, 1, 1);
    cyc(0, 0, 0, 0, 0);
    chk_time("preload", 59, 58, 0);
    run_vec(6, 8);

    cyc(0, 0, 0, 1, 1);
    for (int i = 0; i < 58; i++) cyc(0, 1, 0, 1, 1);
    chk_time("adj_sec58", 0, 58, 0);
    run_vec(9, 13);
    for (int i = 0; i < 59; i++) cyc(0, 1, 0, 0, 1);
    chk_time("adj_min59", 59, 1, 0);
    run_vec(14, 15);

    // pause, ticks frozen, resume
    press(0);
    chk_time("pause", 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
    chk_time("paused_ticks", 0, 1, 1);
    press(0);
    chk("resume.paused", paused, 0);
    cyc(1, 0, 0, 0, 0);
    chk_time("resume_tick", 0, 2, 0);

`ifndef STOPWATCH_DEBOUNCE_EN
    cyc(1, 0, 1, 0, 0);
    chk_time("press_vs_tick", 0, 2, 1);
    cyc(0, 0, 0, 0, 0);
`else
    press(0);
    chk_time("pause2", 0, 2, 1);
`endif

    // press inside adjust is discarded; resume flag keeps pause
    cyc(0, 0, 0, 1, 1);
    chk("adj_from_pause.paused", paused, 1);
    press(1);
    cyc(0, 0, 0, 0, 0);
    chk_time("adj_exit_paused", 0, 2, 1);
    cyc(1, 0, 0, 0, 0);
    chk_time("still_paused_tick", 0, 2, 1);
    press(0);
    cyc(1, 0, 0, 0, 0);
    chk_time("run_again", 0, 3, 0);

    cyc(0, 0, 0, 0, 1);
    press(1);
    cyc(0, 0, 0, 0, 0);
    chk("adj_exit_run.paused", paused, 0);
    cyc(1, 0, 0, 0, 0);
    chk_time("adj_exit_run_tick", 0, 4, 0);

`ifdef STOPWATCH_DEBOUNCE_EN
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
    chk("glitch.paused", paused, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0, 0);
    chk("long_hold.paused", paused, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
    chk("release.paused", paused, 1);
    press(0);
    chk("db_resume.paused", paused, 0);
`endif

    // asynchronous reset mid-operation, with a debounce count in flight
    press(0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    #2 rst = 1'b1; pause_btn = 1'b0;
    #1;
    chk_time("async_rst", 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
`ifdef STOPWATCH_DEBOUNCE_EN
    chk_time("post_rst", 0, 1, 0);
`else
    chk_time("post_rst", 0, 0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
